gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor_pkg.sv | 22 ++
 rtl/sat_counter2.sv | 23 ++
 rtl/gshare_predictor.sv | 163 ++++++++++++++++
 tb/tb_gshare_predictor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare predictor and its helpers.
//   - FSM state encoding (table initialisation sweep, then normal operation)
//   - 2-bit saturating counter encodings and the post-reset initial value
//   - sequential PC increment used for the not-taken next PC
package gshare_predictor_pkg;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } gs_state_e;

  localparam logic [1:0] CntStrongNt = 2'b00;
  localparam logic [1:0] CntWeakNt   = 2'b01;
  localparam logic [1:0] CntWeakT    = 2'b10;
  localparam logic [1:0] CntStrongT  = 2'b11;

  // Every table entry starts out weakly not taken.
  localparam logic [1:0] CntInit = CntWeakNt;

  localparam int unsigned PcIncr = 4;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-value logic (purely combinational).
// Shared by the gshare and pshare tables.
//   i_cnt   : current counter value
//   i_taken : resolved outcome, 1 = count up, 0 = count down
//   o_cnt   : updated counter value, clamped at strong NT / strong T
module sat_counter2
  import gshare_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CntStrongT) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CntStrongNt) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor with delayed, non-speculative training.
//   clock, reset        : rising-edge clock, async active-low reset
//   valid, PC,
//   branch_target       : lookup request, branch address and its taken target
//   fix_valid,
//   fix_result          : outcome of the lookup issued delta_t cycles earlier
//   prediction_gh       : combinational taken prediction
//   gh_PC               : predicted next PC (target or PC + 4)
//   ready               : table initialised, lookups accepted
//   hit, miss           : wrapping correct / incorrect prediction counts
//   fix_error           : sticky, outcome arrived with no pending lookup
// After reset the table is swept to weakly-not-taken one entry per cycle.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned n       = 32,
  parameter int unsigned size    = 10,
  parameter int unsigned delta_t = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid,
  input  logic [n-1:0] PC,
  input  logic [n-1:0] branch_target,
  input  logic         fix_valid,
  input  logic         fix_result,
  output logic         prediction_gh,
  output logic [n-1:0] gh_PC,
  output logic         ready,
  output logic [n-1:0] hit,
  output logic [n-1:0] miss,
  output logic         fix_error
);

  localparam int unsigned Depth = 2 ** size;
  localparam logic [size-1:0] IdxOne = 1;
  localparam logic [n-1:0] CountOne = 1;
  localparam logic [n-1:0] PcStep = n'(PcIncr);

  gs_state_e       r_state, w_state_next;
  logic [size-1:0] r_sweep_idx, w_sweep_next;
  logic [size-1:0] r_ghr;
  logic [1:0]      r_table [Depth];

  // Slot 0 is the newest lookup, slot delta_t-1 the one being resolved.
  logic [delta_t-1:0] r_pend_vld;
  logic [delta_t-1:0] r_pend_pred;
  logic [size-1:0]    r_pend_idx [delta_t];

  logic [n-1:0]    r_hit, r_miss;
  logic            r_fix_error;

  logic            w_run;
  logic            w_accept;
  logic [size-1:0] w_lookup_idx;
  logic [1:0]      w_lookup_cnt;
  logic            w_old_vld;
  logic            w_old_pred;
  logic [size-1:0] w_old_idx;
  logic            w_update;
  logic            w_orphan_fix;
  logic [1:0]      w_upd_cnt_cur;
  logic [1:0]      w_upd_cnt_new;

  // ---------------------------------------------------------------------------
  // Lookup path
  // ---------------------------------------------------------------------------
  assign w_run        = (r_state == StRun);
  assign w_accept     = valid & w_run;
  assign w_lookup_idx = PC[size+1:2] ^ r_ghr;
  // Reads the registered table, so a same-cycle update is not yet visible.
  assign w_lookup_cnt = r_table[w_lookup_idx];

  assign prediction_gh = w_accept & w_lookup_cnt[1];
  assign gh_PC         = prediction_gh ? branch_target : PC + PcStep;
  assign ready         = w_run;
  assign hit           = r_hit;
  assign miss          = r_miss;
  assign fix_error     = r_fix_error;

  // ---------------------------------------------------------------------------
  // Resolution path
  // ---------------------------------------------------------------------------
  assign w_old_vld    = r_pend_vld[delta_t-1];
  assign w_old_pred   = r_pend_pred[delta_t-1];
  assign w_old_idx    = r_pend_idx[delta_t-1];
  assign w_update     = w_run & fix_valid & w_old_vld;
  assign w_orphan_fix = w_run & fix_valid & ~w_old_vld;

  assign w_upd_cnt_cur = r_table[w_old_idx];

  sat_counter2 u_sat_counter2 (
    .i_cnt   (w_upd_cnt_cur),
    .i_taken (fix_result),
    .o_cnt   (w_upd_cnt_new)
  );

  // ---------------------------------------------------------------------------
  // Init / run FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_sweep_next = r_sweep_idx;
    if (r_state == StInit) begin
      w_sweep_next = r_sweep_idx + IdxOne;
      if (&r_sweep_idx) w_state_next = StRun;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StInit;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_idx <= w_sweep_next;
    end
  end

  // Table storage is not reset: the init sweep rewrites every entry.
  always_ff @(posedge clock) begin
    if (r_state == StInit) begin
      r_table[r_sweep_idx] <= CntInit;
    end else if (w_update) begin
      r_table[w_old_idx] <= w_upd_cnt_new;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_vld  <= '0;
      r_pend_pred <= '0;
      for (int i = 0; i < delta_t; i++) r_pend_idx[i] <= '0;
    end else begin
      for (int i = 1; i < delta_t; i++) begin
        r_pend_vld[i]  <= r_pend_vld[i-1];
        r_pend_pred[i] <= r_pend_pred[i-1];
        r_pend_idx[i]  <= r_pend_idx[i-1];
      end
      r_pend_vld[0]  <= w_accept;
      r_pend_pred[0] <= prediction_gh;
      r_pend_idx[0]  <= w_lookup_idx;
    end
  end

  // History is shifted only by resolved outcomes (non-speculative).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ghr       <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_fix_error <= 1'b0;
    end else begin
      if (w_update) begin
        r_ghr <= {r_ghr[size-2:0], fix_result};
        if (w_old_pred == fix_result) r_hit <= r_hit + CountOne;
        else                          r_miss <= r_miss + CountOne;
      end
      if (w_orphan_fix) r_fix_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (size = 4, delta_t = 2).
// Lookups push their hand-computed prediction into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever a lookup is accepted.
module tb_gshare_predictor;

  localparam int unsigned N  = 32;
  localparam int unsigned Sz = 4;
  localparam int unsigned Dt = 2;

  logic          clock;
  logic          reset;
  logic          valid;
  logic [N-1:0]  PC;
  logic [N-1:0]  branch_target;
  logic          fix_valid;
  logic          fix_result;
  logic          prediction_gh;
  logic [N-1:0]  gh_PC;
  logic          ready;
  logic [N-1:0]  hit;
  logic [N-1:0]  miss;
  logic          fix_error;

  gshare_predictor #(
    .n       (N),
    .size    (Sz),
    .delta_t (Dt)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .valid         (valid),
    .PC            (PC),
    .branch_target (branch_target),
    .fix_valid     (fix_valid),
    .fix_result    (fix_result),
    .prediction_gh (prediction_gh),
    .gh_PC         (gh_PC),
    .ready         (ready),
    .hit           (hit),
    .miss          (miss),
    .fix_error     (fix_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic         pred;
    logic [N-1:0] npc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per accepted lookup.
  always @(negedge clock) begin
    if (reset && valid && ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("prediction_gh", {31'd0, prediction_gh}, {31'd0, e.pred});
        check("gh_PC", gh_PC, e.npc);
      end
    end
  end

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic step(input logic v, input logic [N-1:0] pc, input logic [N-1:0] tgt,
                      input logic fv, input logic fr, input logic ep);
    exp_t e;
    valid         = v;
    PC            = pc;
    branch_target = tgt;
    fix_valid     = fv;
    fix_result    = fr;
    if (v) begin
      e.pred = ep;
      e.npc  = ep ? tgt : pc + 32'd4;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fix(input logic fr);
    step(1'b0, 32'd0, 32'd0, 1'b1, fr, 1'b0);
  endtask

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 100) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    check(name, cnt, 32'd16);
  endtask

  task automatic check_stats(input string tag, input int h, input int m, input logic fe);
    check({tag, "_hit"}, hit, h);
    check({tag, "_miss"}, miss, m);
    check({tag, "_fix_error"}, {31'd0, fix_error}, {31'd0, fe});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    PC = '0;
    branch_target = '0;
    fix_valid = 1'b0;
    fix_result = 1'b0;

    // Reset state; lookups ignored while in reset.
    repeat (3) @(posedge clock);
    #1;
    valid = 1'b1;
    PC = 32'h40;
    branch_target = 32'h100;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_pred", {31'd0, prediction_gh}, 32'd0);
    check("rst_gh_PC", gh_PC, 32'h44);
    check_stats("rst", 0, 0, 1'b0);
    valid = 1'b0;

    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_ready("init_cycles");

    // Train entry 0 up to strong taken, keeping the index at 0 via PC choice.
    step(1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 0, cnt 01
    idle();
    fix(1'b1);                                      // miss, cnt 10, ghr 0001
    step(1'b1, 32'h44, 32'h100, 1'b0, 1'b0, 1'b1);  // idx 1^1
    idle();
    fix(1'b1);                                      // hit, cnt 11, ghr 0011
    step(1'b1, 32'h4C, 32'h100, 1'b0, 1'b0, 1'b1);  // idx 3^3
    idle();
    fix(1'b1);                                      // hit, cnt 11, ghr 0111
    check_stats("train", 2, 1, 1'b0);

    // Fourth taken outcome -> ghr 1111.
    step(1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 7
    idle();
    fix(1'b1);                                      // miss, cnt[7] 10, ghr 1111
    step(1'b1, 32'h7C, 32'h200, 1'b0, 1'b0, 1'b1);  // idx F^F = 0
    step(1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 0^F = F
    fix(1'b0);                                      // miss, cnt[0] 10, ghr 1110
    idle();                                         // slot discarded, no update
    check_stats("discard", 2, 3, 1'b0);

    // Outcome arriving for an idle slot.
    fix(1'b0);
    check_stats("orphan", 2, 3, 1'b1);
    step(1'b1, 32'h78, 32'h300, 1'b0, 1'b0, 1'b1);  // idx E^E = 0, cnt 10

    // Same-index lookup and update.
    idle();
    step(1'b1, 32'h78, 32'h300, 1'b1, 1'b0, 1'b1);  // sees old 10; miss, cnt 01, ghr 1100
    step(1'b1, 32'h70, 32'h300, 1'b0, 1'b0, 1'b0);  // idx C^C = 0, cnt 01
    fix(1'b1);                                      // hit, cnt 10, ghr 1001
    fix(1'b0);                                      // hit, cnt 01, ghr 0010
    check_stats("bypass", 4, 4, 1'b1);

    // Saturate down at 00.
    step(1'b1, 32'h48, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 2^2
    idle();
    fix(1'b0);                                      // hit, cnt 00, ghr 0100
    step(1'b1, 32'h50, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 4^4
    idle();
    fix(1'b0);                                      // hit, cnt stays 00, ghr 1000
    step(1'b1, 32'h60, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 8^8
    idle();
    fix(1'b1);                                      // miss, cnt 01, ghr 0001
    step(1'b1, 32'h44, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 1^1, cnt 01
    idle();
    idle();
    check_stats("satdown", 6, 5, 1'b1);

    // Reset mid-operation clears everything, then reset again mid-sweep.
    reset = 1'b0;
    valid = 1'b1;
    PC = 32'h40;
    branch_target = 32'h100;
    #1;
    check("rst2_pred", {31'd0, prediction_gh}, 32'd0);
    check("rst2_gh_PC", gh_PC, 32'h44);
    check("rst2_ready", {31'd0, ready}, 32'd0);
    check_stats("rst2", 0, 0, 1'b0);
    valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    check("sweep9_ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_ready("resweep_cycles");

    // Entry 7 was trained to 10 earlier; the sweep must have restored 01.
    step(1'b1, 32'h5C, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 7, ghr 0
    step(1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);  // idx 0
    idle();
    idle();

    check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
